// File: rtl/smm_pkg.sv
// Shared definitions for the 4x4 Strassen multiplier stream adapter.
//   BLOCKSIZE / BUSWIDTH / N_ELEMS : geometry of the SMM1 bus layout for the default width.
//   smm_state_e                    : adapter FSM encoding.
//   elem_lsb(r, c, dw)             : LSB of element (r,c) inside a row-major packed bus.
package smm_pkg;

    localparam int unsigned DW        = 32;
    localparam int unsigned BLOCKSIZE = 4 * DW;
    localparam int unsigned BUSWIDTH  = 16 * DW;
    localparam int unsigned N_ELEMS   = 16;

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StLoad  = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } smm_state_e;

    function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned dw = DW);
        return (4 * r + c) * dw;
    endfunction

endpackage

// File: rtl/smm_elem_serializer.sv
// Captures a packed bus of NElems elements and streams them out, element 0 first.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   load_i           : capture bus_i and start streaming (restarts at element 0)
//   bus_i            : packed elements, element k at bits [k*DataWidth +: DataWidth]
//   valid_o/ready_i  : output handshake
//   data_o           : current element, stable while stalled
//   last_o           : high with the final element
module smm_elem_serializer
    import smm_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NElems    = N_ELEMS
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic [NElems*DataWidth-1:0] bus_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DataWidth-1:0]        data_o,
    output logic                        last_o
);

    localparam int unsigned IdxW = (NElems > 1) ? $clog2(NElems) : 1;

    logic [DataWidth-1:0] buf_q [NElems];
    logic [IdxW-1:0]      k_q, k_d;
    logic                 valid_q, valid_d;
    logic                 at_last;

    assign at_last = (k_q == IdxW'(NElems - 1));

    always_comb begin
        k_d     = k_q;
        valid_d = valid_q;
        if (load_i) begin
            k_d     = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            if (at_last) begin
                k_d     = '0;
                valid_d = 1'b0;
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NElems); i++) buf_q[i] <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                for (int i = 0; i < int'(NElems); i++) begin
                    buf_q[i] <= bus_i[i*DataWidth +: DataWidth];
                end
            end
            k_q     <= k_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = buf_q[k_q];
    assign last_o  = valid_q && at_last;

endmodule

// File: rtl/smm_stream_adapter.sv
// Streaming front/back end for the 4x4 Strassen multiplier (SMM1 bus layout).
// Collects 16 A then 16 B elements, pulses mm_load, waits MULT_LATENCY cycles,
// captures mm_C and streams its 16 elements out in row-major order.
//   clk, rst                       : clock, synchronous active-high reset
//   sel_in                         : mode, sampled with the first A element
//   in_valid/in_ready/in_data      : element input stream
//   mm_A, mm_B, mm_load, mm_sel    : multiplier operands, start pulse and mode
//   mm_C                           : multiplier result bus
//   out_valid/out_ready/out_data   : element output stream, out_last on element 15
//   busy                           : high outside FILL
module smm_stream_adapter
    import smm_pkg::*;
#(
    parameter int unsigned DATAWIDTH    = 32,
    parameter int unsigned MULT_LATENCY = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATAWIDTH-1:0]          in_data,
    output logic [N_ELEMS*DATAWIDTH-1:0]  mm_A,
    output logic [N_ELEMS*DATAWIDTH-1:0]  mm_B,
    output logic                          mm_load,
    output logic                          mm_sel,
    input  logic [N_ELEMS*DATAWIDTH-1:0]  mm_C,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATAWIDTH-1:0]          out_data,
    output logic                          out_last,
    output logic                          busy
);

    localparam int unsigned CntW = $clog2(MULT_LATENCY + 1);

    smm_state_e           state_q, state_d;
    logic [4:0]           idx_q, idx_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] a_q [N_ELEMS];
    logic [DATAWIDTH-1:0] b_q [N_ELEMS];
    logic                 sel_q;
    logic                 xfer;
    logic                 capture;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        mm_load  = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q == 5'd31) state_d = StLoad;
                end
            end
            StLoad: begin
                mm_load = 1'b1;
                // The LOAD cycle itself is count 1 of the latency.
                cnt_d   = CntW'(1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == CntW'(MULT_LATENCY)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (out_valid && out_ready && out_last) state_d = StFill;
            end
            default: state_d = StFill;
        endcase
    end

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            for (int i = 0; i < int'(N_ELEMS); i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                // idx bit 4 selects B (second half of the input stream).
                if (!idx_q[4]) a_q[idx_q[3:0]] <= in_data;
                else            b_q[idx_q[3:0]] <= in_data;
                if (idx_q == 5'd0) sel_q <= sel_in;
            end
        end
    end

    always_comb begin
        mm_A = '0;
        mm_B = '0;
        for (int i = 0; i < int'(N_ELEMS); i++) begin
            mm_A[elem_lsb(i / 4, i % 4, DATAWIDTH) +: DATAWIDTH] = a_q[i];
            mm_B[elem_lsb(i / 4, i % 4, DATAWIDTH) +: DATAWIDTH] = b_q[i];
        end
    end

    assign mm_sel = sel_q;
    assign busy   = (state_q != StFill);

    smm_elem_serializer #(
        .DataWidth (DATAWIDTH),
        .NElems    (N_ELEMS)
    ) u_out_ser (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (capture),
        .bus_i   (mm_C),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (out_data),
        .last_o  (out_last)
    );

endmodule

// File: tb/tb_smm_stream_adapter.sv
module tb_smm_stream_adapter;

    localparam int DW  = 32;
    localparam int LAT = 6;
    localparam int BW  = 16 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [BW-1:0] mm_A, mm_B, mm_C;
    logic          mm_load, mm_sel;
    logic          out_valid, out_ready, out_last, busy;
    logic [DW-1:0] out_data;

    smm_stream_adapter #(
        .DATAWIDTH    (DW),
        .MULT_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_in    (sel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mm_A      (mm_A),
        .mm_B      (mm_B),
        .mm_load   (mm_load),
        .mm_sel    (mm_sel),
        .mm_C      (mm_C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int load_cnt = 0;
    int load_cyc = -1;

    logic [DW-1:0] elems [32];
    logic [DW-1:0] exp_c [16];
    logic [BW-1:0] pack_a, pack_b;
    logic          sel_cur;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural multiplier: result of a load appears exactly LAT cycles later, noise otherwise.
    initial begin
        logic [DW-1:0] prod [16];
        logic [DW-1:0] acc;
        int  cd;
        bit  armed;
        cd    = 0;
        armed = 0;
        mm_C  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mm_load) begin
                load_cnt++;
                load_cyc = cyc;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        acc = '0;
                        for (int k = 0; k < 4; k++) begin
                            acc = acc + mm_A[(4*r+k)*DW +: DW] * mm_B[(4*k+c)*DW +: DW];
                        end
                        prod[4*r+c] = acc;
                    end
                end
                cd    = LAT;
                armed = 1;
            end else if (cd > 0) begin
                cd--;
            end
            if (armed && cd == 0) begin
                for (int i = 0; i < 16; i++) mm_C[i*DW +: DW] = prod[i];
                armed = 0;
            end else begin
                for (int i = 0; i < 16; i++) mm_C[i*DW +: DW] = $urandom;
            end
        end
    end

    // Expected product and packed operands straight from the element list.
    task automatic build_model();
        logic [DW-1:0] acc;
        for (int i = 0; i < 16; i++) begin
            pack_a[i*DW +: DW] = elems[i];
            pack_b[i*DW +: DW] = elems[16+i];
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc + elems[4*r+k] * elems[16+4*k+c];
                exp_c[4*r+c] = acc;
            end
        end
    endtask

    task automatic send(input int n, input int pct, output int last);
        int i = 0;
        int g = 0;
        last = -1;
        while (i < n && g < 2000) begin
            in_valid = ($urandom_range(99) < pct);
            in_data  = in_valid ? elems[i] : $urandom;
            sel_in   = (i == 0 && in_valid) ? sel_cur : 1'($urandom_range(1));
            if (in_valid && in_ready) begin
                last = cyc;
                i++;
            end
            tick();
            g++;
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("send_count", i, n);
    endtask

    task automatic recv(input int mode);
        int k = 0;
        int g = 0;
        int p = 0;
        bit seen = 0;
        bit stalled = 0;
        logic [DW-1:0] pd;
        logic pl;
        pd = '0;
        pl = 1'b0;
        while (k < 16 && g < 400) begin
            chk("sel_hold", mm_sel, sel_cur);
            if (!out_valid) begin
                out_ready = 1'($urandom_range(1));
                chk("hold_A", mm_A, pack_a);
                chk("hold_B", mm_B, pack_b);
                chk("ready_low_wait", in_ready, 1'b0);
                chk("busy_wait", busy, 1'b1);
            end else begin
                if (!seen) begin
                    seen = 1;
                    chk("first_out_cycle", cyc, load_cyc + LAT + 1);
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (p % 3 == 0);
                    default: out_ready = 1'($urandom_range(1));
                endcase
                p++;
                if (stalled) begin
                    chk("stall_data", out_data, pd);
                    chk("stall_last", out_last, pl);
                end
                chk("out_last", out_last, (k == 15));
                chk("ready_low_drain", in_ready, 1'b0);
                chk("busy_drain", busy, 1'b1);
                if (out_ready) begin
                    chk("out_data", out_data, exp_c[k]);
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = out_data;
                    pl = out_last;
                end
            end
            tick();
            g++;
        end
        chk("drain_count", k, 16);
        chk("busy_after", busy, 1'b0);
        chk("valid_after", out_valid, 1'b0);
        chk("ready_after", in_ready, 1'b1);
        out_ready = 1'($urandom_range(1));
    endtask

    task automatic run(input int pct, input bit sel, input int mode);
        int l0;
        int last;
        sel_cur = sel;
        build_model();
        l0 = load_cnt;
        send(32, pct, last);
        chk("load_cycle", load_cyc, last + 1);
        chk("load_level", mm_load, 1'b1);
        chk("ready_low_load", in_ready, 1'b0);
        chk("sel_load", mm_sel, sel);
        chk("pack_A", mm_A, pack_a);
        chk("pack_B", mm_B, pack_b);
        recv(mode);
        chk("load_count", load_cnt - l0, 1);
    endtask

    task automatic rand_elems();
        for (int i = 0; i < 32; i++) elems[i] = $urandom;
    endtask

    initial begin
        int l0;
        int last;
        rst       = 1'b1;
        sel_in    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sel_cur   = 1'b0;
        repeat (3) tick();

        chk("rst_mm_A", mm_A, '0);
        chk("rst_mm_B", mm_B, '0);
        chk("rst_mm_sel", mm_sel, 1'b0);
        chk("rst_mm_load", mm_load, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Identity A, B = 1..16.
        for (int i = 0; i < 16; i++) elems[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
        for (int i = 0; i < 16; i++) elems[16+i] = 32'(i + 1);
        run(100, 1'b0, 0);

        // Constant: every product element is 4*2*3.
        for (int i = 0; i < 16; i++) elems[i] = 32'd2;
        for (int i = 0; i < 16; i++) elems[16+i] = 32'd3;
        run(100, 1'b0, 2);

        // Input gaps.
        rand_elems();
        run(50, 1'b0, 0);

        // Output backpressure 1,0,0,...
        rand_elems();
        run(100, 1'b1, 1);

        // Reset after 10 A elements, then a full fresh matrix.
        rand_elems();
        sel_cur = 1'b1;
        l0 = load_cnt;
        send(10, 100, last);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mm_A", mm_A, '0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sel", mm_sel, 1'b0);
        rand_elems();
        run(75, 1'b0, 2);
        chk("rst_load_total", load_cnt - l0, 1);

        // Back-to-back runs with different modes.
        rand_elems();
        run(100, 1'b1, 0);
        rand_elems();
        run(100, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
